// File: rtl/dispensador_vuelto_pkg.sv
// ---------------------------------------------------------------------------
// | Package  : pkg_vuelto                                                    |
// | Purpose  : shared state encoding and coin values for the change payout   |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package pkg_vuelto;

  // Payout sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } estado_vuelto_t;

  // Coin values expressed in 100-colon units
  localparam int unsigned VAL_500 = 5;
  localparam int unsigned VAL_100 = 1;

  // Width of the shared cycle timer; must hold max(PULSE, TIMEOUT, GAP) - 1
  localparam int unsigned TIMER_W = 16;

endpackage

`default_nettype wire

// File: rtl/dispensador_vuelto_temporizador.sv
// ---------------------------------------------------------------------------
// | Module   : temporizador_ciclos                                           |
// | Purpose  : load-and-count-down cycle timer with terminal-count flag      |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module temporizador_ciclos #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carga,
  input  logic [WIDTH-1:0] valor,
  output logic             fin
);

  logic [WIDTH-1:0] r_cuenta;

  // Load on request, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cuenta <= '0;
    end else if (carga) begin
      r_cuenta <= valor;
    end else if (r_cuenta != '0) begin
      r_cuenta <= r_cuenta - WIDTH'(1);
    end
  end

  // A load of N-1 makes the owning state last exactly N cycles
  assign fin = (r_cuenta == '0);

endmodule

`default_nettype wire

// File: rtl/dispensador_vuelto.sv
// ---------------------------------------------------------------------------
// | Module   : dispensador_vuelto                                            |
// | Purpose  : pays out change one coin at a time from the 500/100 hoppers,  |
// |            confirming every coin on the exit sensor                      |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module dispensador_vuelto
  import pkg_vuelto::*;
#(
  parameter int W           = 8,
  parameter int PULSE_CYC   = 5,
  parameter int TIMEOUT_CYC = 50,
  parameter int GAP_CYC     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] monto,
  input  logic         sensor_moneda,
  input  logic         vacio500,
  input  logic         vacio100,
  output logic         moneda500,
  output logic         moneda100,
  output logic [W-1:0] restante,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [W-1:0]       c_val_500 = W'(VAL_500);
  localparam logic [W-1:0]       c_val_100 = W'(VAL_100);
  localparam logic [TIMER_W-1:0] c_t_pulso  = TIMER_W'(PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] c_t_espera = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] c_t_gap    = TIMER_W'(GAP_CYC - 1);

  estado_vuelto_t     r_estado;
  logic               r_sel500;      // coin in flight is a 500
  logic               r_confirmado;  // sensor already seen for this coin
  logic [W-1:0]       w_r_eval;
  logic [W-1:0]       w_valor_moneda;
  logic               w_inicio;
  logic               w_usa500;
  logic               w_usa100;
  logic               w_fin;
  logic               w_carga;
  logic [TIMER_W-1:0] w_valor_timer;

  assign w_inicio       = start && ((r_estado == IDLE) || (r_estado == ERROR));
  // The decision rule looks at the new request when starting, else at what is owed
  assign w_r_eval       = (r_estado == GAP) ? restante : monto;
  assign w_usa500       = (w_r_eval >= c_val_500) && !vacio500;
  assign w_usa100       = !w_usa500 && (w_r_eval >= c_val_100) && !vacio100;
  assign w_valor_moneda = r_sel500 ? c_val_500 : c_val_100;

  // Timer reload: every entry into PULSE, WAIT or GAP restarts the count
  always_comb begin
    w_carga       = 1'b0;
    w_valor_timer = c_t_pulso;
    unique case (r_estado)
      IDLE, ERROR: begin
        if (w_inicio && (monto != '0) && (w_usa500 || w_usa100)) begin
          w_carga       = 1'b1;
          w_valor_timer = c_t_pulso;
        end
      end
      PULSE: begin
        if (w_fin) begin
          w_carga       = 1'b1;
          w_valor_timer = (r_confirmado || sensor_moneda) ? c_t_gap : c_t_espera;
        end
      end
      WAIT: begin
        if (sensor_moneda) begin
          w_carga       = 1'b1;
          w_valor_timer = c_t_gap;
        end
      end
      GAP: begin
        if (w_fin && (restante != '0) && (w_usa500 || w_usa100)) begin
          w_carga       = 1'b1;
          w_valor_timer = c_t_pulso;
        end
      end
      default: begin
        w_carga       = 1'b0;
        w_valor_timer = c_t_pulso;
      end
    endcase
  end

  temporizador_ciclos #(
    .WIDTH (TIMER_W)
  ) u_temporizador (
    .clk   (clk),
    .rst   (rst),
    .carga (w_carga),
    .valor (w_valor_timer),
    .fin   (w_fin)
  );

  // Payout sequencer with registered solenoid, amount and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado     <= IDLE;
      r_sel500     <= 1'b0;
      r_confirmado <= 1'b0;
      moneda500    <= 1'b0;
      moneda100    <= 1'b0;
      restante     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      unique case (r_estado)
        IDLE, ERROR: begin
          if (w_inicio) begin
            restante     <= monto;
            busy         <= 1'b1;
            error        <= 1'b0;
            r_confirmado <= 1'b0;
            if (monto == '0) begin
              r_estado <= DONE;
              done     <= 1'b1;
            end else if (w_usa500) begin
              r_estado  <= PULSE;
              r_sel500  <= 1'b1;
              moneda500 <= 1'b1;
            end else if (w_usa100) begin
              r_estado  <= PULSE;
              r_sel500  <= 1'b0;
              moneda100 <= 1'b1;
            end else begin
              // Amount owed but the needed hopper is empty
              r_estado <= ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        PULSE: begin
          // An early sensor pulse is credited now; the solenoid still runs full width
          if (sensor_moneda && !r_confirmado) begin
            restante     <= restante - w_valor_moneda;
            r_confirmado <= 1'b1;
          end
          if (w_fin) begin
            moneda500 <= 1'b0;
            moneda100 <= 1'b0;
            r_estado  <= (r_confirmado || sensor_moneda) ? GAP : WAIT;
          end
        end

        WAIT: begin
          if (sensor_moneda) begin
            restante     <= restante - w_valor_moneda;
            r_confirmado <= 1'b1;
            r_estado     <= GAP;
          end else if (w_fin) begin
            r_estado <= ERROR;
            error    <= 1'b1;
            busy     <= 1'b0;
          end
        end

        GAP: begin
          if (w_fin) begin
            r_confirmado <= 1'b0;
            if (restante == '0) begin
              r_estado <= DONE;
              done     <= 1'b1;
            end else if (w_usa500) begin
              r_estado  <= PULSE;
              r_sel500  <= 1'b1;
              moneda500 <= 1'b1;
            end else if (w_usa100) begin
              r_estado  <= PULSE;
              r_sel500  <= 1'b0;
              moneda100 <= 1'b1;
            end else begin
              r_estado <= ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          r_estado <= IDLE;
        end

        default: begin
          r_estado  <= IDLE;
          moneda500 <= 1'b0;
          moneda100 <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dispensador_vuelto.sv
// ---------------------------------------------------------------------------
// | Module   : tb_dispensador_vuelto                                         |
// | Purpose  : scoreboard bench for the change payout block                  |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dispensador_vuelto;

  localparam int W           = 8;
  localparam int PULSE_CYC   = 5;
  localparam int TIMEOUT_CYC = 50;
  localparam int GAP_CYC     = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] monto;
  logic         sensor_moneda;
  logic         vacio500;
  logic         vacio100;
  logic         moneda500;
  logic         moneda100;
  logic [W-1:0] restante;
  logic         busy;
  logic         done;
  logic         error;

  typedef struct {
    bit es500;
    int rest;
  } item_t;

  item_t q_esperado[$];
  int    n_cmp;
  int    n_err;
  bit    modelo_err;
  int    modelo_rest;

  dispensador_vuelto #(
    .W           (W),
    .PULSE_CYC   (PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .monto         (monto),
    .sensor_moneda (sensor_moneda),
    .vacio500      (vacio500),
    .vacio100      (vacio100),
    .moneda500     (moneda500),
    .moneda100     (moneda100),
    .restante      (restante),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chequear(input string tag, input int obs, input int esp);
    n_cmp++;
    if (obs != esp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // Reference decision rule: pushes the coins a transaction should produce
  task automatic push_modelo(input int m, input bit v5, input bit v1);
    int r;
    r           = m;
    modelo_err  = 1'b0;
    modelo_rest = 0;
    while (r > 0) begin
      if (r >= 5 && !v5) begin
        r -= 5;
        q_esperado.push_back('{1'b1, r});
      end else if (!v1) begin
        r -= 1;
        q_esperado.push_back('{1'b0, r});
      end else begin
        modelo_err  = 1'b1;
        modelo_rest = r;
        break;
      end
    end
  endtask

  task automatic arrancar(input int m);
    start = 1'b1;
    monto = W'(m);
    @(negedge clk);
    start = 1'b0;
  endtask

  // modo 0: sensor during the pulse (plus a duplicate), 1: sensor 2 cycles
  // after the fall, 2: no sensor, 3: reset mid-pulse
  task automatic moneda(input int modo, input bit chk_gap);
    int    espera;
    int    w;
    bit    es500;
    item_t e;
    espera = 0;
    while (!(moneda500 || moneda100) && espera < 200) begin
      espera++;
      @(negedge clk);
    end
    if (!(moneda500 || moneda100)) begin
      chequear("moneda_timeout", 0, 1);
      return;
    end
    if (chk_gap) chequear("gap_ciclos", espera, GAP_CYC);
    chequear("exclusion", int'(moneda500 && moneda100), 0);
    es500 = moneda500;
    if (q_esperado.size() == 0) begin
      chequear("cola_vacia", 1, 0);
      return;
    end
    e = q_esperado.pop_front();
    chequear("tipo_500", int'(es500), int'(e.es500));
    w = 0;
    while ((es500 ? moneda500 : moneda100) && w < 20) begin
      w++;
      if (modo == 3 && w == 2) begin
        rst = 1'b0;
        #1;
        chequear("rst_moneda500", int'(moneda500), 0);
        chequear("rst_moneda100", int'(moneda100), 0);
        chequear("rst_busy", int'(busy), 0);
        chequear("rst_restante", int'(restante), 0);
        return;
      end
      sensor_moneda = (modo == 0) && (w == 2 || w == 4);
      @(negedge clk);
    end
    sensor_moneda = 1'b0;
    chequear("ancho_pulso", w, PULSE_CYC);
    if (modo == 1) begin
      repeat (2) @(negedge clk);
      sensor_moneda = 1'b1;
      @(negedge clk);
      sensor_moneda = 1'b0;
    end
    if (modo != 2) chequear("restante", int'(restante), e.rest);
  endtask

  task automatic esperar_fin();
    int n;
    int c;
    bit vista;
    n     = 0;
    c     = 0;
    vista = 1'b0;
    while (c < 100) begin
      if (done) n++;
      if (moneda500 || moneda100) vista = 1'b1;
      if (n > 0 && !busy) break;
      c++;
      @(negedge clk);
    end
    chequear("done_pulsos", n, 1);
    chequear("busy_fin", int'(busy), 0);
    chequear("restante_fin", int'(restante), 0);
    chequear("moneda_en_fin", int'(vista), 0);
  endtask

  task automatic esperar_error(output int ciclos);
    ciclos = 0;
    while (!error && ciclos < 200) begin
      if (moneda500 || moneda100) chequear("moneda_antes_error", 1, 0);
      ciclos++;
      @(negedge clk);
    end
    chequear("error_visto", int'(error), 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b0;
    start         = 1'b0;
    monto         = '0;
    sensor_moneda = 1'b0;
    vacio500      = 1'b0;
    vacio100      = 1'b0;
    repeat (3) @(negedge clk);
    chequear("reset_moneda500", int'(moneda500), 0);
    chequear("reset_moneda100", int'(moneda100), 0);
    chequear("reset_restante", int'(restante), 0);
    chequear("reset_busy", int'(busy), 0);
    chequear("reset_done", int'(done), 0);
    chequear("reset_error", int'(error), 0);
    rst = 1'b1;
    @(negedge clk);

    // T1: zero change completes immediately
    arrancar(0);
    chequear("t1_done", int'(done), 1);
    esperar_fin();

    // T2: 8 -> one 500 then three 100, sensor after each pulse
    push_modelo(8, 1'b0, 1'b0);
    arrancar(8);
    chequear("t2_restante_ini", int'(restante), 8);
    chequear("t2_busy", int'(busy), 1);
    repeat (4) moneda(1, 1'b0);
    esperar_fin();
    chequear("t2_cola", q_esperado.size(), 0);

    // T3: 500 hopper empty -> eleven 100 coins, back to back
    vacio500 = 1'b1;
    push_modelo(11, 1'b1, 1'b0);
    arrancar(11);
    for (int i = 0; i < 11; i++) moneda(0, i > 0);
    esperar_fin();
    chequear("t3_cola", q_esperado.size(), 0);
    vacio500 = 1'b0;

    // T4: sensor never fires -> timeout error, then a new start clears it
    push_modelo(3, 1'b0, 1'b0);
    arrancar(3);
    moneda(2, 1'b0);
    esperar_error(c);
    chequear("t4_timeout_ciclos", c, TIMEOUT_CYC);
    chequear("t4_restante", int'(restante), 3);
    chequear("t4_busy", int'(busy), 0);
    q_esperado.delete();
    push_modelo(1, 1'b0, 1'b0);
    arrancar(1);
    chequear("t4_error_limpio", int'(error), 0);
    chequear("t4_busy_nuevo", int'(busy), 1);
    moneda(1, 1'b0);
    esperar_fin();

    // T5: 100 hopper empty -> one 500 paid, then error with 2 owed
    vacio100 = 1'b1;
    push_modelo(7, 1'b0, 1'b1);
    arrancar(7);
    moneda(1, 1'b0);
    esperar_error(c);
    chequear("t5_modelo_err", int'(modelo_err), 1);
    chequear("t5_restante", int'(restante), modelo_rest);
    chequear("t5_busy", int'(busy), 0);
    chequear("t5_cola", q_esperado.size(), 0);
    vacio100 = 1'b0;

    // T6: start while busy ignored; reset mid-pulse clears outputs at once
    push_modelo(6, 1'b0, 1'b0);
    arrancar(6);
    chequear("t6_error_limpio", int'(error), 0);
    moneda(0, 1'b0);
    start = 1'b1;
    monto = W'(9);
    @(negedge clk);
    start = 1'b0;
    moneda(3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    c   = 0;
    repeat (10) begin
      @(negedge clk);
      if (moneda500 || moneda100 || busy) c++;
    end
    chequear("t6_sin_resume", c, 0);
    chequear("t6_error", int'(error), 0);
    chequear("t6_cola", q_esperado.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
